// File: rtl/fp_adder.sv
// Two-stage binary16 adder, round-to-nearest-even, subnormals flushed to zero.
// Stage 1 unpacks, orders by magnitude and aligns; stage 2 adds, normalises, rounds and packs.
module fp_adder (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Sum
);

  // ---------------- stage 1: unpack / swap / align ----------------
  logic        w_sa, w_sb, w_za, w_zb;
  logic [4:0]  w_ea, w_eb;
  logic [9:0]  w_fa, w_fb;
  logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic [14:0] w_mag_a, w_mag_b;
  logic        w_swap, w_sx;
  logic [4:0]  w_ex, w_ey, w_d;
  logic [10:0] w_sig_a, w_sig_b, w_sigx, w_sigy;
  logic [27:0] w_ywide;
  logic [13:0] w_yal;
  logic        w_spec;
  logic [15:0] w_spec_val;

  assign w_sa = A[15];
  assign w_sb = B[15];
  assign w_ea = A[14:10];
  assign w_eb = B[14:10];
  assign w_fa = A[9:0];
  assign w_fb = B[9:0];

  assign w_za    = (w_ea == 5'd0);
  assign w_zb    = (w_eb == 5'd0);
  assign w_nan_a = (w_ea == 5'h1f) && (|w_fa);
  assign w_nan_b = (w_eb == 5'h1f) && (|w_fb);
  assign w_inf_a = (w_ea == 5'h1f) && !(|w_fa);
  assign w_inf_b = (w_eb == 5'h1f) && !(|w_fb);

  // Subnormal inputs contribute nothing: magnitude and significand forced to zero
  assign w_mag_a = w_za ? 15'd0 : A[14:0];
  assign w_mag_b = w_zb ? 15'd0 : B[14:0];
  assign w_sig_a = w_za ? 11'd0 : {1'b1, w_fa};
  assign w_sig_b = w_zb ? 11'd0 : {1'b1, w_fb};

  assign w_swap = (w_mag_b > w_mag_a);
  assign w_sx   = w_swap ? w_sb : w_sa;
  assign w_ex   = w_swap ? w_mag_b[14:10] : w_mag_a[14:10];
  assign w_ey   = w_swap ? w_mag_a[14:10] : w_mag_b[14:10];
  assign w_sigx = w_swap ? w_sig_b : w_sig_a;
  assign w_sigy = w_swap ? w_sig_a : w_sig_b;
  assign w_d    = w_ex - w_ey;

  // Upper 14 bits are the aligned significand with G/R/S; lower 14 catch bits shifted past S
  assign w_ywide = {w_sigy, 3'b000, 14'd0} >> w_d;
  assign w_yal   = (w_d >= 5'd14) ? {13'd0, |w_sigy}
                                  : {w_ywide[27:15], w_ywide[14] | (|w_ywide[13:0])};

  always_comb begin
    w_spec     = 1'b1;
    w_spec_val = 16'h0000;
    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb)))
      w_spec_val = 16'h7E00;
    else if (w_inf_a)
      w_spec_val = {w_sa, 15'h7C00};
    else if (w_inf_b)
      w_spec_val = {w_sb, 15'h7C00};
    else
      w_spec = 1'b0;
  end

  logic        r_spec, r_sx, r_sub;
  logic [15:0] r_spec_val;
  logic [4:0]  r_ex;
  logic [13:0] r_mx, r_my;

  always_ff @(posedge CLK) begin
    if (RESETn) begin
      r_spec     <= 1'b0;
      r_spec_val <= 16'h0000;
      r_sx       <= 1'b0;
      r_sub      <= 1'b0;
      r_ex       <= 5'd0;
      r_mx       <= 14'd0;
      r_my       <= 14'd0;
    end else begin
      r_spec     <= w_spec;
      r_spec_val <= w_spec_val;
      r_sx       <= w_sx;
      r_sub      <= (w_sa != w_sb);
      r_ex       <= w_ex;
      r_mx       <= {w_sigx, 3'b000};
      r_my       <= w_yal;
    end
  end

  // ---------------- stage 2: add / normalise / round / pack ----------------
  logic [14:0]       w_sum;
  logic [3:0]        w_lz;
  logic [13:0]       w_norm;
  logic signed [6:0] w_en, w_er;
  logic              w_rup;
  logic [11:0]       w_mr;
  logic [9:0]        w_mant;
  logic [15:0]       w_res;

  // X is never smaller than aligned Y, so the subtraction cannot go negative
  assign w_sum = r_sub ? ({1'b0, r_mx} - {1'b0, r_my})
                       : ({1'b0, r_mx} + {1'b0, r_my});

  always_comb begin
    w_lz = 4'd0;
    for (int i = 0; i < 14; i++)
      if (w_sum[i]) w_lz = 4'(13 - i);
  end

  always_comb begin
    if (w_sum[14]) begin
      w_norm = {w_sum[14:2], w_sum[1] | w_sum[0]};
      w_en   = $signed({2'b00, r_ex}) + 7'sd1;
    end else begin
      w_norm = w_sum[13:0] << w_lz;
      w_en   = $signed({2'b00, r_ex}) - $signed({3'b000, w_lz});
    end
  end

  assign w_rup  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_mr   = {1'b0, w_norm[13:3]} + {11'd0, w_rup};
  assign w_mant = w_mr[11] ? w_mr[10:1] : w_mr[9:0];
  assign w_er   = w_mr[11] ? (w_en + 7'sd1) : w_en;

  always_comb begin
    if (w_sum == 15'd0)
      w_res = {~r_sub & r_sx, 15'd0};
    else if (w_er >= 7'sd31)
      w_res = {r_sx, 5'h1f, 10'd0};
    else if (w_er <= 7'sd0)
      w_res = {r_sx, 15'd0};
    else
      w_res = {r_sx, w_er[4:0], w_mant};
  end

  logic [15:0] r_sum;

  always_ff @(posedge CLK) begin
    if (RESETn) r_sum <= 16'h0000;
    else        r_sum <= r_spec ? r_spec_val : w_res;
  end

  assign Sum = r_sum;

endmodule

// File: tb/tb_fp_adder.sv
// Streaming bench for fp_adder: directed vectors plus random pairs checked
// against an exact-integer reference of binary16 addition.
module tb_fp_adder;
  logic        CLK = 1'b0;
  logic        RESETn = 1'b1;
  logic [15:0] A = 16'h0000, B = 16'h0000;
  logic [15:0] Sum;
  int          checks = 0, errors = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  fp_adder dut (.CLK(CLK), .RESETn(RESETn), .A(A), .B(B), .Sum(Sum));

  always #5 CLK = ~CLK;

  // Operand value scaled by 2^24 so every normal binary16 is an integer
  function automatic longint fval(input logic [15:0] x);
    longint v;
    if (x[14:10] == 5'd0) return 0;
    v = longint'({1'b1, x[9:0]}) << (int'(x[14:10]) - 1);
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic   na, nb, ia, ib, sg;
    longint s, mag, q, rem, half;
    int     p, sh, e;
    na = (a[14:10] == 5'h1f) && (a[9:0] != 0);
    nb = (b[14:10] == 5'h1f) && (b[9:0] != 0);
    ia = (a[14:10] == 5'h1f) && (a[9:0] == 0);
    ib = (b[14:10] == 5'h1f) && (b[9:0] == 0);
    if (na || nb) return 16'h7E00;
    if (ia && ib) return (a[15] == b[15]) ? a : 16'h7E00;
    if (ia) return a;
    if (ib) return b;
    s = fval(a) + fval(b);
    if (s == 0) return {a[15] & b[15], 15'd0};
    sg  = (s < 0);
    mag = sg ? -s : s;
    for (p = 62; p > 0 && !mag[p]; p--) ;
    e  = p - 9;
    sh = p - 10;
    if (sh > 0) begin
      q    = mag >> sh;
      rem  = mag & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == 2048) begin q = 1024; e++; end
    end else begin
      q = mag << (-sh);
    end
    if (e >= 31) return {sg, 5'h1f, 10'd0};
    if (e <= 0)  return {sg, 15'd0};
    return {sg, 5'(e), q[9:0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: Sum=%h expected %h", tag, obs, expv);
    end
  endtask

  // One clock per call: retire the result of the pair driven two edges ago, then drive a new pair
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input string tag,
                       input logic [15:0] expv);
    @(negedge CLK);
    if (exp_q.size() == 2) check(tag_q.pop_front(), Sum, exp_q.pop_front());
    RESETn = 1'b0;
    A = a;
    B = b;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    repeat (2) drive(16'h0000, 16'h0000, "idle", 16'h0000);
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    RESETn = 1'b1;
    A = 16'($urandom);
    B = 16'($urandom);
    exp_q.delete();
    tag_q.delete();
    repeat (n) begin
      @(negedge CLK);
      check("reset", Sum, 16'h0000);
      A = 16'($urandom);
      B = 16'($urandom);
    end
  endtask

  task automatic rand_run(input int n);
    logic [15:0] a, b;
    int          ex;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 3))
        1: begin b = a ^ 16'h8000; b[3:0] = 4'($urandom); end
        2: b[14:10] = a[14:10];
        3: begin
          ex = int'(a[14:10]) - int'($urandom_range(0, 15));
          b[14:10] = (ex < 0) ? 5'd0 : 5'(ex);
        end
        default: ;
      endcase
      drive(a, b, $sformatf("rand %h+%h", a, b), ref_add(a, b));
    end
  endtask

  logic [15:0] dv_a[12] = '{16'h59EC, 16'h5A28, 16'h4F30, 16'h570C, 16'hD211, 16'h3C00,
                            16'h8000, 16'h0000, 16'h7BFF, 16'h7C00, 16'h7E01, 16'h0001};
  logic [15:0] dv_b[12] = '{16'h57A6, 16'h59CD, 16'h4B14, 16'hD552, 16'h595C, 16'hBC00,
                            16'h8000, 16'h4500, 16'h7BFF, 16'hFC00, 16'h3C00, 16'h3C00};
  logic [15:0] dv_e[12] = '{16'h5CE0, 16'h5DFA, 16'h515D, 16'h4EE8, 16'h57B0, 16'h0000,
                            16'h8000, 16'h4500, 16'h7C00, 16'h7E00, 16'h7E00, 16'h3C00};

  initial begin
    do_reset(3);

    // Directed vectors streamed on consecutive edges
    for (int i = 0; i < 12; i++)
      drive(dv_a[i], dv_b[i], $sformatf("dir%0d %h+%h", i, dv_a[i], dv_b[i]), dv_e[i]);
    drain();

    // A few specials not covered above
    drive(16'hFC00, 16'h4000, "ninf+fin", 16'hFC00);
    drive(16'h7C00, 16'h7C00, "inf+inf", 16'h7C00);
    drive(16'h8000, 16'h0000, "-0++0", 16'h0000);
    drive(16'h3C00, 16'h7D00, "fin+nan", 16'h7E00);
    drain();

    rand_run(1500);

    // Reset in the middle of a stream discards in-flight results
    do_reset(2);
    rand_run(1500);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_adder.md
Name: fp_adder

Overview:
- Pipelined IEEE 754 binary16 (half-precision) adder: Sum = A + B, round-to-nearest-even.
- Arithmetic leaf of the floating-point MAC datapath; fed by operand registers or the multiplier output.
- Fixed two-cycle latency, one new operand pair accepted every clock, no handshake.

Parameters:
- None. The format is fixed: 1 sign bit, 5 exponent bits (bias 15), 10 fraction bits.

Ports:
- CLK  input  1  rising-edge clock.
- RESETn  input  1  synchronous reset, active-high (1 = reset), sampled on the rising edge of CLK.
- A  input  16  binary16 operand.
- B  input  16  binary16 operand.
- Sum  output  16  binary16 result, registered.

Behaviour:
- Reset: any rising edge with RESETn=1 clears all pipeline registers. Sum=16'h0000 from that edge. Inputs are ignored while reset is held.
- Reset mid-operation: in-flight results are discarded. The first valid Sum appears 2 edges after the first edge with RESETn=0.
- Pipeline:
  - Stage 1 (edge k): capture A and B. Unpack. Swap so the larger magnitude is the operand X. Align Y right by the exponent difference, keeping guard, round and sticky bits.
  - Stage 2 (edge k+1): add or subtract the significands (effective subtract when signs differ). Normalise, round, pack, then register into Sum.
  - The result of the inputs sampled at edge k is visible on Sum after edge k+1 (2-register latency). Throughput is 1 per cycle.
- Significands: hidden 1 plus 10 fraction bits, extended by 3 bits (G, R, S).
  - Alignment shift amounts of 14 or more collapse Y entirely into S.
- Normalisation:
  - Carry-out: shift right 1, exponent +1, OR the shifted-out bit into S.
  - Cancellation: leading-zero count, shift left, exponent minus count.
- Rounding, RNE: round up when G=1 and (R|S|LSB)=1. A rounding carry that overflows the mantissa increments the exponent.
- Overflow: a biased exponent of 31 or more after rounding gives signed infinity (7C00/FC00).
- Subnormals:
  - Flush-to-zero on inputs: exponent 0 is treated as a signed zero.
  - Results with biased exponent ≤0 flush to a signed zero.
- Zeros:
  - x + (−x) = +0 (0000).
  - (−0) + (−0) = 8000.
  - 0 + y = y, exactly.
- Special values:
  - Any NaN input (exp=31, frac≠0) gives canonical qNaN 7E00.
  - +Inf + −Inf gives 7E00.
  - Inf + finite gives that Inf.
  - Same-sign Infs give that Inf.
- Sign of a nonzero result is the sign of the larger-magnitude operand.
- Equal exponents: swap on fraction compare.
- Purely synchronous; no combinational path from A/B to Sum.

Test Plan:
- Reset: RESETn=1 for 3 edges with arbitrary A/B -> Sum=0000. Release RESETn=0 -> first valid Sum 2 edges later.
- Addition with ties:
  - A=59EC, B=57A6 -> Sum=5CE0 (189.5+122.375; tie rounds up to even).
  - A=5A28, B=59CD -> Sum=5DFA (tie, stays even).
  - A=4F30, B=4B14 -> Sum=515D, exact.
- Subtraction/mixed signs:
  - A=570C, B=D552 -> Sum=4EE8 (112.75−85.125).
  - A=D211, B=595C -> Sum=57B0 (tie rounds to even 944).
- Cancellation and zeros:
  - A=3C00, B=BC00 -> Sum=0000.
  - A=8000, B=8000 -> Sum=8000.
  - A=0000, B=4500 -> Sum=4500.
- Specials:
  - A=7BFF, B=7BFF -> Sum=7C00 (overflow).
  - A=7C00, B=FC00 -> Sum=7E00.
  - A=7E01, B=3C00 -> Sum=7E00.
  - A=0001 (subnormal), B=3C00 -> Sum=3C00.
- Back-to-back streaming: apply the five addition vectors on consecutive edges -> results emerge in order on consecutive edges, each exactly 2 edges after its input.
